// File: rtl/ars_proj2affine.sv
// Projective-to-affine converter: drives the GF(2^233) inverter for Z^-1, then forms
// x = X * Z^-1 with an MSB-first bit-serial multiplier reduced by t^233 + t^RED_TAP + 1.
module ars_proj2affine #(
    parameter int unsigned M       = 233,
    parameter int unsigned RED_TAP = 74,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [M-1:0] X_IN,
    input  logic [M-1:0] Z_IN,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic         INV_RST_N,
    output logic [M-1:0] INV_DIN,
    output logic         INV_IN_VALID,
    input  logic [M-1:0] INV_DOUT,
    input  logic         INV_OUT_VALID,
    output logic [M-1:0] X_AFF,
    output logic         OUT_VALID,
    output logic         ERR
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = $clog2(M);

    typedef enum logic [2:0] {
        StIdle,
        StZchk,
        StInvClr,
        StInvLaunch,
        StInvWait,
        StMul,
        StDone,
        StFail
    } state_e;

    state_e          state_q;
    logic [M-1:0]    x_q;
    logic [M-1:0]    zinv_q;
    logic [M-1:0]    acc_q;
    logic [BW-1:0]   bit_q;
    logic [TW-1:0]   tmo_q;

    logic [M-1:0]    acc_shift;
    logic [M-1:0]    acc_step;

    // One multiplier step: acc*t mod f, then add X when the current Zinv bit is set.
    always_comb begin
        acc_shift = {acc_q[M-2:0], 1'b0};
        if (acc_q[M-1]) begin
            acc_shift[0]       = 1'b1;
            acc_shift[RED_TAP] = acc_shift[RED_TAP] ^ 1'b1;
        end
        acc_step = acc_shift ^ (zinv_q[bit_q] ? x_q : '0);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            x_q          <= '0;
            zinv_q       <= '0;
            acc_q        <= '0;
            bit_q        <= '0;
            tmo_q        <= '0;
            IN_READY     <= 1'b1;
            INV_RST_N    <= 1'b1;
            INV_DIN      <= '0;
            INV_IN_VALID <= 1'b0;
            X_AFF        <= '0;
            OUT_VALID    <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            INV_RST_N    <= 1'b1;
            INV_IN_VALID <= 1'b0;
            OUT_VALID    <= 1'b0;
            ERR          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (IN_VALID) begin
                        x_q      <= X_IN;
                        INV_DIN  <= Z_IN;
                        IN_READY <= 1'b0;
                        state_q  <= StZchk;
                    end
                end
                StZchk: begin
                    if (INV_DIN == '0) begin
                        ERR     <= 1'b1;
                        state_q <= StFail;
                    end else begin
                        // Clears the inverter's sticky valid left from the previous pair.
                        INV_RST_N <= 1'b0;
                        state_q   <= StInvClr;
                    end
                end
                StInvClr: begin
                    INV_IN_VALID <= 1'b1;
                    state_q      <= StInvLaunch;
                end
                StInvLaunch: begin
                    tmo_q   <= '0;
                    state_q <= StInvWait;
                end
                StInvWait: begin
                    if (INV_OUT_VALID) begin
                        zinv_q  <= INV_DOUT;
                        acc_q   <= '0;
                        bit_q   <= BW'(M - 1);
                        state_q <= StMul;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (tmo_q == TW'(TIMEOUT - 1)) begin
                            ERR     <= 1'b1;
                            state_q <= StFail;
                        end
                    end
                end
                StMul: begin
                    acc_q <= acc_step;
                    bit_q <= bit_q - 1'b1;
                    if (bit_q == '0) begin
                        X_AFF     <= acc_step;
                        OUT_VALID <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    IN_READY <= 1'b1;
                    state_q  <= StIdle;
                end
                StFail: begin
                    IN_READY <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ars_proj2affine.sv
// Bench for ars_proj2affine: stub inverter, GF(2^233) software model and a result scoreboard.
module tb_ars_proj2affine;

    localparam int M = 233;
    localparam int TMO = 16;

    typedef logic [M-1:0] fe_t;
    typedef struct {
        bit  is_err;
        fe_t x;
        int  lat;
        bit  from_w;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    fe_t  X_IN, Z_IN, INV_DIN, INV_DOUT, X_AFF;
    logic IN_VALID, IN_READY, INV_RST_N, INV_IN_VALID, INV_OUT_VALID, OUT_VALID, ERR;

    ars_proj2affine #(.M(M), .RED_TAP(74), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .X_IN(X_IN), .Z_IN(Z_IN), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .INV_RST_N(INV_RST_N), .INV_DIN(INV_DIN),
        .INV_IN_VALID(INV_IN_VALID), .INV_DOUT(INV_DOUT), .INV_OUT_VALID(INV_OUT_VALID),
        .X_AFF(X_AFF), .OUT_VALID(OUT_VALID), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int w_cyc = 0;
    bit cur_zero = 0;
    fe_t cur_z = '0;
    fe_t model_xaff = '0;
    exp_t sb[$];

    task automatic check_eq(input string tag, input fe_t act, input fe_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Software field model (LSB-first multiply, Fermat inversion).
    function automatic fe_t gf_xt(input fe_t a);
        fe_t r;
        r = a << 1;
        if (a[M-1]) begin
            r[0]  = r[0] ^ 1'b1;
            r[74] = r[74] ^ 1'b1;
        end
        return r;
    endfunction

    function automatic fe_t gf_mul(input fe_t a, input fe_t b);
        fe_t r = '0;
        fe_t s = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ s;
            s = gf_xt(s);
        end
        return r;
    endfunction

    function automatic fe_t gf_inv(input fe_t a);
        fe_t r = fe_t'(1);
        fe_t sq = gf_mul(a, a);
        for (int k = 1; k < M; k++) begin
            r  = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic fe_t rnd_fe();
        fe_t v = '0;
        repeat (8) v = {v[M-33:0], 32'($urandom)};
        return v;
    endfunction

    // Stub inverter: sticky valid, cleared only by INV_RST_N.
    bit  stub_never = 0;
    bit  stub_force = 0;
    fe_t stub_force_val = '0;
    int  stub_lat = 10;
    int  stub_cnt = 0;
    fe_t stub_val = '0;
    fe_t stub_dout = '0;
    logic stub_valid = 1'b0;
    assign INV_DOUT = stub_dout;
    assign INV_OUT_VALID = stub_valid;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!INV_RST_N) begin
            stub_valid <= 1'b0;
            stub_cnt   <= 0;
        end else if (INV_IN_VALID) begin
            if (!stub_never) begin
                stub_cnt <= stub_lat;
                stub_val <= stub_force ? stub_force_val : gf_inv(INV_DIN);
            end
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_valid <= 1'b1;
                stub_dout  <= stub_val;
            end
        end
    end

    logic prev_iov = 1'b0;
    logic prev_ov = 1'b0;
    bit   chk_ready = 0;

    always @(negedge CLK) begin
        exp_t e;
        int r;
        if (RST_N) begin
            if (INV_OUT_VALID && !prev_iov) w_cyc = cyc;
            prev_iov = INV_OUT_VALID;
            if (chk_ready) begin
                check_eq("ready_after_out", fe_t'(IN_READY), fe_t'(1));
                chk_ready = 0;
            end
            if (!INV_RST_N)
                check_eq("inv_clr_cycle", fe_t'(cyc - acc_cyc), cur_zero ? '1 : fe_t'(2));
            if (INV_IN_VALID) begin
                check_eq("inv_launch_cycle", fe_t'(cyc - acc_cyc), cur_zero ? '1 : fe_t'(3));
                check_eq("inv_din", INV_DIN, cur_z);
            end
            if (OUT_VALID) check_eq("out_valid_pulse", fe_t'(prev_ov), '0);
            prev_ov = OUT_VALID;
            if (OUT_VALID || ERR) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", fe_t'({OUT_VALID, ERR}), '0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_kind", fe_t'({OUT_VALID, ERR}),
                             e.is_err ? fe_t'(1) : fe_t'(2));
                    if (!e.is_err) model_xaff = e.x;
                    check_eq("x_aff", X_AFF, model_xaff);
                    r = e.from_w ? w_cyc : acc_cyc;
                    check_eq("latency", fe_t'(cyc - r), fe_t'(e.lat));
                end
                chk_ready = 1;
            end
        end
    end

    function automatic exp_t mk_ok(input fe_t x);
        exp_t e;
        e.is_err = 0;
        e.x      = x;
        e.lat    = M + 1;
        e.from_w = 1;
        return e;
    endfunction

    function automatic exp_t mk_err(input int lat);
        exp_t e;
        e.is_err = 1;
        e.x      = '0;
        e.lat    = lat;
        e.from_w = 0;
        return e;
    endfunction

    // Called at a negedge; presents one pair as soon as the block is ready.
    task automatic send(input fe_t x, input fe_t z, input exp_t e);
        int n = 0;
        while (!IN_READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            check_eq("ready_wait", fe_t'(IN_READY), fe_t'(1));
            return;
        end
        X_IN = x;
        Z_IN = z;
        IN_VALID = 1'b1;
        acc_cyc = cyc;
        cur_z = z;
        cur_zero = (z == '0);
        sb.push_back(e);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_done(input bit junk);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            if (junk && !IN_READY && ($urandom_range(0, 3) == 0)) begin
                IN_VALID = 1'b1;
                X_IN = rnd_fe();
                Z_IN = rnd_fe();
            end else begin
                IN_VALID = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        IN_VALID = 1'b0;
        if (sb.size() != 0) begin
            check_eq("done_timeout", fe_t'(sb.size()), '0);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    task automatic check_reset_state();
        check_eq("rst_in_ready", fe_t'(IN_READY), fe_t'(1));
        check_eq("rst_inv_rst_n", fe_t'(INV_RST_N), fe_t'(1));
        check_eq("rst_inv_in_valid", fe_t'(INV_IN_VALID), '0);
        check_eq("rst_inv_din", INV_DIN, '0);
        check_eq("rst_x_aff", X_AFF, '0);
        check_eq("rst_out_valid", fe_t'(OUT_VALID), '0);
        check_eq("rst_err", fe_t'(ERR), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fe_t x, z, x2, z2, t233;
        int n;
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        X_IN = '0;
        Z_IN = '0;
        repeat (3) @(negedge CLK);
        check_reset_state();
        RST_N = 1'b1;
        @(negedge CLK);

        // Z = 1 with the stub returning 1: x passes through unchanged.
        stub_force = 1;
        stub_force_val = fe_t'(1);
        stub_lat = 10;
        send(fe_t'(32'h1ABC), fe_t'(1), mk_ok(fe_t'(32'h1ABC)));
        wait_done(0);

        // t * t^232 = t^233 = t^74 + 1.
        stub_force_val = '0;
        stub_force_val[M-1] = 1'b1;
        t233 = '0;
        t233[74] = 1'b1;
        t233[0] = 1'b1;
        send(fe_t'(2), fe_t'(5), mk_ok(t233));
        wait_done(0);

        // Point at infinity.
        send(fe_t'(32'h55), '0, mk_err(2));
        wait_done(0);

        // Inverter never answers: 16 wait cycles then ERR.
        stub_never = 1;
        send(fe_t'(7), fe_t'(3), mk_err(4 + TMO));
        wait_done(0);
        stub_never = 0;
        stub_force = 0;

        // Back-to-back pair; the stub's valid stays high from the first result.
        stub_lat = 6;
        x = rnd_fe(); z = rnd_fe() | fe_t'(1);
        x2 = rnd_fe(); z2 = rnd_fe() | fe_t'(2);
        send(x, z, mk_ok(gf_mul(x, gf_inv(z))));
        send(x2, z2, mk_ok(gf_mul(x2, gf_inv(z2))));
        wait_done(0);

        // Random pairs with ignored IN_VALID pulses while busy.
        for (int k = 0; k < 3; k++) begin
            stub_lat = $urandom_range(1, 12);
            x = rnd_fe();
            z = rnd_fe();
            if (z == '0) z = fe_t'(1);
            send(x, z, mk_ok(gf_mul(x, gf_inv(z))));
            wait_done(1);
        end

        // Reset mid-multiply: abort without any output, then a clean op.
        stub_lat = 5;
        x = rnd_fe(); z = rnd_fe() | fe_t'(4);
        send(x, z, mk_ok(gf_mul(x, gf_inv(z))));
        while (cyc - acc_cyc < 4) @(negedge CLK);
        n = 0;
        while (!INV_OUT_VALID && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_eq("abort_inv_seen", fe_t'(INV_OUT_VALID), fe_t'(1));
        repeat (100) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check_reset_state();
        RST_N = 1'b1;
        sb.delete();
        model_xaff = '0;
        chk_ready = 0;
        repeat (300) @(negedge CLK);
        check_eq("abort_x_aff", X_AFF, '0);
        x = rnd_fe(); z = rnd_fe() | fe_t'(8);
        send(x, z, mk_ok(gf_mul(x, gf_inv(z))));
        wait_done(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
